// File: rtl/axi_write_port_arbiter.sv
// axi_write_port_arbiter
// Two-master AXI4 write-channel (AW/W/B) arbiter in front of a single RAM write port.
// Owns one transaction at a time, from the AW handshake through the B handshake.
// Round-robin by default. Define AXI_WARB_FIXED_PRIORITY_EN to make master 0 always
// win contention.
module axi_write_port_arbiter #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ID_WIDTH   = 8
) (
   input  logic                        axi_clk,
   input  logic                        axi_resetn,
   // master 0
   input  logic [AXI_ADDR_WIDTH-1:0]   s0_aw_addr,
   input  logic [1:0]                  s0_aw_burst,
   input  logic [2:0]                  s0_aw_size,
   input  logic [AXI_ID_WIDTH-1:0]     s0_aw_id,
   input  logic [7:0]                  s0_aw_len,
   input  logic                        s0_aw_valid,
   output logic                        s0_aw_ready,
   input  logic [AXI_DATA_WIDTH-1:0]   s0_w_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] s0_w_strb,
   input  logic                        s0_w_last,
   input  logic                        s0_w_valid,
   output logic                        s0_w_ready,
   output logic [1:0]                  s0_b_resp,
   output logic [AXI_ID_WIDTH-1:0]     s0_b_id,
   output logic                        s0_b_valid,
   input  logic                        s0_b_ready,
   // master 1
   input  logic [AXI_ADDR_WIDTH-1:0]   s1_aw_addr,
   input  logic [1:0]                  s1_aw_burst,
   input  logic [2:0]                  s1_aw_size,
   input  logic [AXI_ID_WIDTH-1:0]     s1_aw_id,
   input  logic [7:0]                  s1_aw_len,
   input  logic                        s1_aw_valid,
   output logic                        s1_aw_ready,
   input  logic [AXI_DATA_WIDTH-1:0]   s1_w_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] s1_w_strb,
   input  logic                        s1_w_last,
   input  logic                        s1_w_valid,
   output logic                        s1_w_ready,
   output logic [1:0]                  s1_b_resp,
   output logic [AXI_ID_WIDTH-1:0]     s1_b_id,
   output logic                        s1_b_valid,
   input  logic                        s1_b_ready,
   // RAM write port
   output logic [AXI_ADDR_WIDTH-1:0]   m_aw_addr,
   output logic [1:0]                  m_aw_burst,
   output logic [2:0]                  m_aw_size,
   output logic [AXI_ID_WIDTH-1:0]     m_aw_id,
   output logic [7:0]                  m_aw_len,
   output logic                        m_aw_valid,
   input  logic                        m_aw_ready,
   output logic [AXI_DATA_WIDTH-1:0]   m_w_data,
   output logic [AXI_DATA_WIDTH/8-1:0] m_w_strb,
   output logic                        m_w_last,
   output logic                        m_w_valid,
   input  logic                        m_w_ready,
   input  logic [1:0]                  m_b_resp,
   input  logic [AXI_ID_WIDTH-1:0]     m_b_id,
   input  logic                        m_b_valid,
   output logic                        m_b_ready
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t state_q, state_d;
   logic   grant_q, grant_d;            // 0 = master 0 owns the port, 1 = master 1
   logic   last_grant_q, last_grant_d;  // winner of the previous arbitration

   // State, grant and round-robin history registers; reset drops any transaction in flight
   always_ff @(posedge axi_clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Arbitration in IDLE, then walk AW -> W (until last beat) -> B for the granted master
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         IDLE: begin
            if (s0_aw_valid || s1_aw_valid) begin
`ifdef AXI_WARB_FIXED_PRIORITY_EN
               grant_d = !s0_aw_valid;
`else
               if (s0_aw_valid && s1_aw_valid) begin
                  grant_d = !last_grant_q;
               end else begin
                  grant_d = s1_aw_valid;
               end
`endif
               last_grant_d = grant_d;
               state_d      = ADDR;
            end
         end
         ADDR: begin
            if (m_aw_valid && m_aw_ready) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (m_w_valid && m_w_ready && m_w_last) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (m_b_valid && m_b_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Combinational routing from the registered grant; each channel is only live in its own state
   always_comb begin
      m_aw_addr   = grant_q ? s1_aw_addr  : s0_aw_addr;
      m_aw_burst  = grant_q ? s1_aw_burst : s0_aw_burst;
      m_aw_size   = grant_q ? s1_aw_size  : s0_aw_size;
      m_aw_id     = grant_q ? s1_aw_id    : s0_aw_id;
      m_aw_len    = grant_q ? s1_aw_len   : s0_aw_len;
      m_aw_valid  = (state_q == ADDR) && (grant_q ? s1_aw_valid : s0_aw_valid);
      s0_aw_ready = (state_q == ADDR) && !grant_q && m_aw_ready;
      s1_aw_ready = (state_q == ADDR) &&  grant_q && m_aw_ready;

      m_w_data    = grant_q ? s1_w_data : s0_w_data;
      m_w_strb    = grant_q ? s1_w_strb : s0_w_strb;
      m_w_last    = grant_q ? s1_w_last : s0_w_last;
      m_w_valid   = (state_q == DATA) && (grant_q ? s1_w_valid : s0_w_valid);
      s0_w_ready  = (state_q == DATA) && !grant_q && m_w_ready;
      s1_w_ready  = (state_q == DATA) &&  grant_q && m_w_ready;

      s0_b_resp   = m_b_resp;
      s0_b_id     = m_b_id;
      s1_b_resp   = m_b_resp;
      s1_b_id     = m_b_id;
      s0_b_valid  = (state_q == RESP) && !grant_q && m_b_valid;
      s1_b_valid  = (state_q == RESP) &&  grant_q && m_b_valid;
      m_b_ready   = (state_q == RESP) && (grant_q ? s1_b_ready : s0_b_ready);
   end

endmodule

// File: tb/tb_axi_write_port_arbiter.sv
// Testbench for axi_write_port_arbiter: two master drivers, a RAM-like slave model and
// a scoreboard of expected transactions in grant order.
module tb_axi_write_port_arbiter;

   logic clk = 1'b0;
   logic axi_resetn = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] s_aw_addr  [2];
   logic [1:0]  s_aw_burst [2];
   logic [2:0]  s_aw_size  [2];
   logic [7:0]  s_aw_id    [2];
   logic [7:0]  s_aw_len   [2];
   logic        s_aw_valid [2];
   logic        s_aw_ready [2];
   logic [31:0] s_w_data   [2];
   logic [3:0]  s_w_strb   [2];
   logic        s_w_last   [2];
   logic        s_w_valid  [2];
   logic        s_w_ready  [2];
   logic [1:0]  s_b_resp   [2];
   logic [7:0]  s_b_id     [2];
   logic        s_b_valid  [2];
   logic        s_b_ready  [2];

   logic [31:0] m_aw_addr;
   logic [1:0]  m_aw_burst;
   logic [2:0]  m_aw_size;
   logic [7:0]  m_aw_id;
   logic [7:0]  m_aw_len;
   logic        m_aw_valid;
   logic        m_aw_ready;
   logic [31:0] m_w_data;
   logic [3:0]  m_w_strb;
   logic        m_w_last;
   logic        m_w_valid;
   logic        m_w_ready;
   logic [1:0]  m_b_resp;
   logic [7:0]  m_b_id;
   logic        m_b_valid;
   logic        m_b_ready;

   axi_write_port_arbiter #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(8)) dut (
      .axi_clk(clk), .axi_resetn(axi_resetn),
      .s0_aw_addr(s_aw_addr[0]), .s0_aw_burst(s_aw_burst[0]), .s0_aw_size(s_aw_size[0]),
      .s0_aw_id(s_aw_id[0]), .s0_aw_len(s_aw_len[0]), .s0_aw_valid(s_aw_valid[0]),
      .s0_aw_ready(s_aw_ready[0]), .s0_w_data(s_w_data[0]), .s0_w_strb(s_w_strb[0]),
      .s0_w_last(s_w_last[0]), .s0_w_valid(s_w_valid[0]), .s0_w_ready(s_w_ready[0]),
      .s0_b_resp(s_b_resp[0]), .s0_b_id(s_b_id[0]), .s0_b_valid(s_b_valid[0]),
      .s0_b_ready(s_b_ready[0]),
      .s1_aw_addr(s_aw_addr[1]), .s1_aw_burst(s_aw_burst[1]), .s1_aw_size(s_aw_size[1]),
      .s1_aw_id(s_aw_id[1]), .s1_aw_len(s_aw_len[1]), .s1_aw_valid(s_aw_valid[1]),
      .s1_aw_ready(s_aw_ready[1]), .s1_w_data(s_w_data[1]), .s1_w_strb(s_w_strb[1]),
      .s1_w_last(s_w_last[1]), .s1_w_valid(s_w_valid[1]), .s1_w_ready(s_w_ready[1]),
      .s1_b_resp(s_b_resp[1]), .s1_b_id(s_b_id[1]), .s1_b_valid(s_b_valid[1]),
      .s1_b_ready(s_b_ready[1]),
      .m_aw_addr(m_aw_addr), .m_aw_burst(m_aw_burst), .m_aw_size(m_aw_size),
      .m_aw_id(m_aw_id), .m_aw_len(m_aw_len), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
      .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last), .m_w_valid(m_w_valid),
      .m_w_ready(m_w_ready), .m_b_resp(m_b_resp), .m_b_id(m_b_id), .m_b_valid(m_b_valid),
      .m_b_ready(m_b_ready)
   );

   typedef struct {
      int          master;
      logic [31:0] addr;
      logic [7:0]  id;
      logic [7:0]  len;
      logic [31:0] base;
      logic [1:0]  resp;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   int          checks = 0;
   int          errors = 0;
   int          sl_beat = 0;
   bit          b_pend = 1'b0;
   bit          w_toggle = 1'b0;
   bit          mon_en = 1'b0;
   int          s1_bad = 0;
   logic [31:0] mem [256];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   function automatic logic [8:0] hs_outs();
      return {m_aw_valid, m_w_valid, m_b_ready, s_aw_ready[0], s_aw_ready[1],
              s_w_ready[0], s_w_ready[1], s_b_valid[0], s_b_valid[1]};
   endfunction

   task automatic push_exp(input int k, input logic [31:0] addr, input logic [7:0] id,
                           input logic [7:0] len, input logic [31:0] base, input logic [1:0] resp);
      exp_t e;
      e.master = k; e.addr = addr; e.id = id; e.len = len; e.base = base; e.resp = resp;
      exp_q.push_back(e);
   endtask

   // One complete write from master k; starts and ends just after a rising edge.
   task automatic master_write(input int k, input logic [31:0] addr, input logic [7:0] id,
                               input logic [7:0] len, input logic [31:0] base,
                               input logic [1:0] exp_resp, input int w_early,
                               input int b_delay, input int exp_cycles);
      int cyc = 0, aw_cyc = 0, beat = 0, viol = 0, guard = 0, wait_b = 0, held = 0, extra = 0;
      bit aw_done = 0, w_done = 0, b_done = 0, aborted = 0;
      bit aw_hs, w_hs, b_hs;
      s_w_data[k] = base;
      s_w_strb[k] = 4'hF;
      s_w_last[k] = (len == 8'd0);
      if (w_early > 0) begin
         s_w_valid[k] = 1'b1;
         repeat (w_early) begin
            @(negedge clk);
            if (s_w_ready[k]) viol++;
            @(posedge clk); #1;
         end
      end
      s_aw_addr[k] = addr; s_aw_id[k] = id; s_aw_len[k] = len;
      s_aw_burst[k] = 2'b01; s_aw_size[k] = 3'd2;
      s_aw_valid[k] = 1'b1;
      s_w_valid[k]  = 1'b1;
      s_b_ready[k]  = (b_delay == 0);
      while (!b_done && guard < 2000) begin
         @(negedge clk);
         if (!axi_resetn) begin
            aborted = 1'b1;
            break;
         end
         aw_hs = s_aw_valid[k] && s_aw_ready[k];
         w_hs  = s_w_valid[k] && s_w_ready[k];
         b_hs  = s_b_valid[k] && s_b_ready[k];
         if (!aw_done && s_w_ready[k]) viol++;
         if (s_b_valid[k] && !s_b_ready[k]) held++;
         if (b_hs) begin
            chk("b_id", 64'(s_b_id[k]), 64'(id));
            chk("b_resp", 64'(s_b_resp[k]), 64'(exp_resp));
            $display("txn m%0d addr=%08h id=%02h len=%0d resp=%0d", k, addr, id, len, s_b_resp[k]);
         end
         @(posedge clk);
         cyc++; guard++;
         #1;
         if (aw_hs) begin
            aw_done = 1'b1; aw_cyc = cyc; s_aw_valid[k] = 1'b0;
         end
         if (w_hs) begin
            if (s_w_last[k]) begin
               w_done = 1'b1; s_w_valid[k] = 1'b0;
            end else begin
               beat++;
               s_w_data[k] = base + 32'(beat);
               s_w_last[k] = (beat == int'(len));
            end
         end
         if (w_done && !b_done && !b_hs) begin
            if (wait_b >= b_delay) s_b_ready[k] = 1'b1;
            wait_b++;
         end
         if (b_hs) begin
            b_done = 1'b1; s_b_ready[k] = 1'b0;
         end
      end
      if (aborted) begin
         s_aw_valid[k] = 1'b0; s_w_valid[k] = 1'b0; s_b_ready[k] = 1'b0;
      end else begin
         chk("txn_done", 64'(b_done), 64'd1);
         chk("w_held_before_aw", 64'(viol), 64'd0);
         if (b_delay > 0) chk("b_held_cycles", 64'(held), 64'(b_delay));
         if (exp_cycles > 0) begin
            chk("aw_latency", 64'(aw_cyc), 64'd2);
            chk("occupancy", 64'(cyc), 64'(exp_cycles));
         end
         repeat (3) begin
            @(negedge clk);
            if (s_b_valid[k]) extra++;
         end
         chk("b_once", 64'(extra), 64'd0);
         @(posedge clk); #1;
      end
   endtask

   // RAM-like slave: pops the scoreboard on AW, checks beats, stores data, answers on B
   initial begin
      bit aw_hs, w_hs, b_hs;
      logic [7:0] idx;
      m_aw_ready = 1'b1; m_w_ready = 1'b1; m_b_valid = 1'b0; m_b_resp = 2'b00; m_b_id = 8'h00;
      forever begin
         @(negedge clk);
         aw_hs = m_aw_valid && m_aw_ready;
         w_hs  = m_w_valid && m_w_ready;
         b_hs  = m_b_valid && m_b_ready;
         if (aw_hs) begin
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               cur = exp_q.pop_front();
               chk("grant_master", 64'(s_aw_ready[1]), 64'(cur.master));
               chk("aw_addr", 64'(m_aw_addr), 64'(cur.addr));
               chk("aw_id", 64'(m_aw_id), 64'(cur.id));
               chk("aw_len", 64'(m_aw_len), 64'(cur.len));
               chk("aw_burst", 64'(m_aw_burst), 64'd1);
               sl_beat = 0;
            end
         end
         if (w_hs) begin
            chk("w_data", 64'(m_w_data), 64'(cur.base + 32'(sl_beat)));
            idx = cur.addr[9:2] + 8'(sl_beat);
            for (int b = 0; b < 4; b++) begin
               if (m_w_strb[b]) mem[idx][b*8 +: 8] = m_w_data[b*8 +: 8];
            end
            if (m_w_last) begin
               chk("w_beats", 64'(sl_beat), 64'(cur.len));
               b_pend = 1'b1;
            end
            sl_beat++;
         end
         @(posedge clk); #1;
         if (!axi_resetn) begin
            m_b_valid = 1'b0; b_pend = 1'b0; sl_beat = 0; m_w_ready = 1'b1;
         end else begin
            if (b_hs) m_b_valid = 1'b0;
            if (b_pend) begin
               m_b_valid = 1'b1; m_b_id = cur.id; m_b_resp = cur.resp; b_pend = 1'b0;
            end
            m_w_ready = w_toggle ? !m_w_ready : 1'b1;
         end
      end
   end

   // Master 1 must see no ready/valid while only master 0 is active
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && (s_aw_ready[1] || s_w_ready[1] || s_b_valid[1])) s1_bad++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         s_aw_addr[k] = (k == 0) ? 32'h55 : 32'hAA;
         s_aw_burst[k] = 2'b01; s_aw_size[k] = 3'd2; s_aw_id[k] = 8'h00; s_aw_len[k] = 8'h00;
         s_aw_valid[k] = 1'b0; s_w_data[k] = 32'h0; s_w_strb[k] = 4'h0; s_w_last[k] = 1'b0;
         s_w_valid[k] = 1'b0; s_b_ready[k] = 1'b0;
      end
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;

      // reset state
      #12;
      chk("rst_outs", 64'(hs_outs()), 64'd0);
      chk("rst_payload_known", 64'($isunknown({m_aw_addr, m_w_data, m_aw_id})), 64'd0);
      chk("rst_grant0_mux", 64'(m_aw_addr), 64'h55);
      @(posedge clk); #1;
      axi_resetn = 1'b1;

      // simultaneous requests twice: 0,1,0,1
      for (int r = 0; r < 2; r++) begin
         push_exp(0, 32'h40 + 32'(r*64), 8'h10 + 8'(r), 8'd1, 32'h1000 + 32'(r*16), 2'b00);
         push_exp(1, 32'h80 + 32'(r*64), 8'h20 + 8'(r), 8'd0, 32'h2000 + 32'(r*16), 2'b00);
         fork
            master_write(0, 32'h40 + 32'(r*64), 8'h10 + 8'(r), 8'd1, 32'h1000 + 32'(r*16), 2'b00, 0, 0, -1);
            master_write(1, 32'h80 + 32'(r*64), 8'h20 + 8'(r), 8'd0, 32'h2000 + 32'(r*16), 2'b00, 0, 0, -1);
         join
      end

      // fresh reset, then a single master-0 burst with master 1 silent
      axi_resetn = 1'b0;
      @(posedge clk); #1;
      axi_resetn = 1'b1;
      mon_en = 1'b1;
      push_exp(0, 32'h100, 8'h3C, 8'd3, 32'hC0DE0000, 2'b00);
      master_write(0, 32'h100, 8'h3C, 8'd3, 32'hC0DE0000, 2'b00, 0, 0, 7);
      mon_en = 1'b0;
      chk("s1_quiet", 64'(s1_bad), 64'd0);

      // minimum occupancy with a slave error response passed through
      push_exp(1, 32'h180, 8'h7E, 8'd0, 32'h0BADF00D, 2'b10);
      master_write(1, 32'h180, 8'h7E, 8'd0, 32'h0BADF00D, 2'b10, 0, 0, 4);

      // W presented two cycles before AW
      push_exp(1, 32'h200, 8'h44, 8'd2, 32'h77770000, 2'b00);
      master_write(1, 32'h200, 8'h44, 8'd2, 32'h77770000, 2'b00, 2, 0, -1);

      // backpressure on W and B
      w_toggle = 1'b1;
      push_exp(0, 32'h240, 8'h55, 8'd3, 32'h33330000, 2'b00);
      master_write(0, 32'h240, 8'h55, 8'd3, 32'h33330000, 2'b00, 0, 5, -1);
      w_toggle = 1'b0;
      @(posedge clk); #1;

      // reset in the middle of a len=7 burst
      push_exp(0, 32'h300, 8'h66, 8'd7, 32'h99990000, 2'b00);
      fork
         master_write(0, 32'h300, 8'h66, 8'd7, 32'h99990000, 2'b00, 0, 0, -1);
         begin
            int g = 0;
            do begin
               @(negedge clk); #1;
               g++;
            end while (sl_beat != 2 && g < 200);
            chk("mid_burst_reached", 64'(sl_beat), 64'd2);
            @(posedge clk); #2;
            chk("mid_burst_active", 64'(s_w_ready[0]), 64'd1);
            axi_resetn = 1'b0;
            #1;
            chk("rst_mid_outs", 64'(hs_outs()), 64'd0);
            @(posedge clk); @(posedge clk); #3;
            axi_resetn = 1'b1;
         end
      join
      push_exp(1, 32'h400, 8'h88, 8'd0, 32'hFEED0001, 2'b00);
      master_write(1, 32'h400, 8'h88, 8'd0, 32'hFEED0001, 2'b00, 0, 0, 4);

      // alternating writes, then read back the slave memory
      push_exp(0, 32'h0, 8'h01, 8'd0, 32'hA5A5A5A5, 2'b00);
      master_write(0, 32'h0, 8'h01, 8'd0, 32'hA5A5A5A5, 2'b00, 0, 0, -1);
      push_exp(1, 32'h4, 8'h02, 8'd0, 32'h5A5A5A5A, 2'b00);
      master_write(1, 32'h4, 8'h02, 8'd0, 32'h5A5A5A5A, 2'b00, 0, 0, -1);
      chk("readback_0x0", 64'(mem[0]), 64'hA5A5A5A5);
      chk("readback_0x4", 64'(mem[1]), 64'h5A5A5A5A);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
